// File: rtl/bc_pkg.sv
// Shared state encoding and datapath select/op constants for the polynomial controller.
package bc_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL1   = 3'd2,
        ADD1   = 3'd3,
        MUL2   = 3'd4,
        ADD2   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [1:0] SEL0_NONE = 2'b00;
    localparam logic [1:0] SEL0_A    = 2'b01;
    localparam logic [1:0] SEL0_B    = 2'b10;
    localparam logic [1:0] SEL0_C    = 2'b11;

    localparam logic [1:0] SEL1_M0 = 2'b00;
    localparam logic [1:0] SEL1_R0 = 2'b01;
    localparam logic [1:0] SEL1_R1 = 2'b10;
    localparam logic [1:0] SEL1_R2 = 2'b11;

    localparam logic [1:0] SEL2_R0 = 2'b00;
    localparam logic [1:0] SEL2_M0 = 2'b01;
    localparam logic [1:0] SEL2_R1 = 2'b10;
    localparam logic [1:0] SEL2_R2 = 2'b11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    function automatic logic is_alu_step(input state_t s);
        return (s == MUL1) || (s == ADD1) || (s == MUL2) || (s == ADD2);
    endfunction

endpackage

// File: rtl/bc_step_timer.sv
// Hold-cycle counter for one ALU step; last marks the final cycle of the step.
module bc_step_timer #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    import bc_pkg::*;

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(ALU_LAT - 1));

    // Wraps to zero on the final cycle so the next step starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || last) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bc_poly_ctrl.sv
// Horner sequencer for P = (A*x + B)*x + C; drives all datapath selects and load strobes.
// Define BC_ABORT_EN to add the abort input.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_X | load R0 with x
// MUL1   | R1 <= A * R0
// ADD1   | R1 <= R1 + B
// MUL2   | R1 <= R1 * R0
// ADD2   | R2 <= R1 + C
// DONE   | result valid in R2, one-cycle done pulse
module bc_poly_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef BC_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H,
    output logic       LX,
    output logic       LH,
    output logic       LS
);
    import bc_pkg::*;

    state_t state;
    logic   step;
    logic   last;
    logic   abort_hit;
    logic   fire;

    assign step = is_alu_step(state);

`ifdef BC_ABORT_EN
    assign abort_hit = abort && (step || (state == LOAD_X));
`else
    assign abort_hit = 1'b0;
`endif

    assign fire = last && !abort_hit;

    bc_step_timer #(.ALU_LAT(ALU_LAT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!step || abort_hit),
        .enable (step),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (abort_hit) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= LOAD_X;
                LOAD_X:  state <= MUL1;
                MUL1:    if (last) state <= ADD1;
                ADD1:    if (last) state <= MUL2;
                MUL2:    if (last) state <= ADD2;
                ADD2:    if (last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode; strobes are suppressed in a cycle where abort wins.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        M0   = SEL0_NONE;
        M1   = SEL1_M0;
        M2   = SEL2_R0;
        H    = OP_ADD;
        LX   = 1'b0;
        LH   = 1'b0;
        LS   = 1'b0;
        case (state)
            LOAD_X: begin
                busy = 1'b1;
                LX   = !abort_hit;
            end
            MUL1: begin
                busy = 1'b1;
                M0   = SEL0_A;
                M1   = SEL1_M0;
                M2   = SEL2_R0;
                H    = OP_MUL;
                LH   = fire;
            end
            ADD1: begin
                busy = 1'b1;
                M0   = SEL0_B;
                M1   = SEL1_R1;
                M2   = SEL2_M0;
                H    = OP_ADD;
                LH   = fire;
            end
            MUL2: begin
                busy = 1'b1;
                M0   = SEL0_NONE;
                M1   = SEL1_R1;
                M2   = SEL2_R0;
                H    = OP_MUL;
                LH   = fire;
            end
            ADD2: begin
                busy = 1'b1;
                M0   = SEL0_C;
                M1   = SEL1_R1;
                M2   = SEL2_M0;
                H    = OP_ADD;
                LS   = fire;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bc_poly_ctrl.sv
// Bench for bc_poly_ctrl: an ALU_LAT=1 instance driving a behavioural datapath and an ALU_LAT=3 instance.
// Covers the abort input when BC_ABORT_EN is defined.
module tb_bc_poly_ctrl;

    typedef logic [11:0] ov_t;  // {busy, done, M0, M1, M2, H, LX, LH, LS}

    localparam ov_t STROBES = 12'h003;
    localparam ov_t V_IDLE  = 12'h000;
    localparam ov_t V_LX    = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ov_t V_MUL1  = {1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ov_t V_ADD1  = {1'b1, 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ov_t V_MUL2  = {1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ov_t V_ADD2  = {1'b1, 1'b0, 2'b11, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ov_t V_DONE  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
`ifdef BC_ABORT_EN
    logic abort1 = 1'b0;
    logic abort3 = 1'b0;
`endif

    logic       busy1, done1, H1, LX1, LH1, LS1;
    logic [1:0] M0_1, M1_1, M2_1;
    logic       busy3, done3, H3, LX3, LH3, LS3;
    logic [1:0] M0_3, M1_3, M2_3;

    bc_poly_ctrl #(.ALU_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
`ifdef BC_ABORT_EN
        .abort (abort1),
`endif
        .start (start1),
        .busy  (busy1),
        .done  (done1),
        .M0    (M0_1),
        .M1    (M1_1),
        .M2    (M2_1),
        .H     (H1),
        .LX    (LX1),
        .LH    (LH1),
        .LS    (LS1)
    );

    bc_poly_ctrl #(.ALU_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst   (rst),
`ifdef BC_ABORT_EN
        .abort (abort3),
`endif
        .start (start3),
        .busy  (busy3),
        .done  (done3),
        .M0    (M0_3),
        .M1    (M1_3),
        .M2    (M2_3),
        .H     (H3),
        .LX    (LX3),
        .LH    (LH3),
        .LS    (LS3)
    );

    // Behavioural datapath hung off the ALU_LAT=1 controller.
    logic [15:0] a_in = '0, b_in = '0, c_in = '0, x_in = '0;
    logic [15:0] r0, r1, r2, m0_out, p1, p2, alu;

    always_comb begin
        m0_out = '0;
        case (M0_1)
            2'b01:   m0_out = a_in;
            2'b10:   m0_out = b_in;
            2'b11:   m0_out = c_in;
            default: m0_out = '0;
        endcase
        case (M1_1)
            2'b01:   p1 = r0;
            2'b10:   p1 = r1;
            2'b11:   p1 = r2;
            default: p1 = m0_out;
        endcase
        case (M2_1)
            2'b01:   p2 = m0_out;
            2'b10:   p2 = r1;
            2'b11:   p2 = r2;
            default: p2 = r0;
        endcase
        alu = H1 ? (p1 * p2) : (p1 + p2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            if (LX1) r0 <= x_in;
            if (LH1) r1 <= alu;
            if (LS1) r2 <= alu;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    ov_t         expq[$];
    logic [15:0] r2q[$];

    function automatic ov_t obs(input bit u3);
        if (u3) return {busy3, done3, M0_3, M1_3, M2_3, H3, LX3, LH3, LS3};
        return {busy1, done1, M0_1, M1_1, M2_1, H1, LX1, LH1, LS1};
    endfunction

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_trace(input bit u3);
        int  lat;
        ov_t steps[4];
        lat   = u3 ? 3 : 1;
        steps = '{V_MUL1, V_ADD1, V_MUL2, V_ADD2};
        expq.push_back(V_LX);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < lat - 1; k++) expq.push_back(steps[s] & ~STROBES);
            expq.push_back(steps[s]);
        end
        expq.push_back(V_DONE);
        expq.push_back(V_IDLE);
    endtask

    task automatic launch(input bit u3, input int a, input int b, input int c, input int x);
        a_in = 16'(a);
        b_in = 16'(b);
        c_in = 16'(c);
        x_in = 16'(x);
        push_trace(u3);
        if (!u3) r2q.push_back(16'((a * x + b) * x + c));
        if (u3) start3 = 1'b1;
        else    start1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic step(input bit u3, input logic st, input string tag);
        ov_t e;
        e = expq.pop_front();
        chk(tag, 16'(obs(u3)), 16'(e));
        if (e[10] && !u3) chk({tag, "_r2"}, r2, r2q.pop_front());
        if (u3) start3 = st;
        else    start1 = st;
        @(negedge clk);
    endtask

    task automatic seq(input bit u3, input logic [15:0] pat, input int n, input string tag);
        for (int i = 0; i < n; i++) step(u3, pat[i], tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_u1", 16'(obs(0)), 16'(V_IDLE));
        chk("rst_async_u3", 16'(obs(1)), 16'(V_IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        launch(0, 1, 0, 3, 4);
        seq(0, 16'h0000, 7, "lat1_run_a");
        launch(0, 2, 3, 5, 3);
        seq(0, 16'h0000, 7, "lat1_run_b");

        launch(1, 1, 0, 3, 4);
        seq(1, 16'h0000, 15, "lat3_run");

        // start pulses during MUL2 (index 3) and DONE (index 5) must be ignored
        launch(0, 2, 3, 5, 3);
        seq(0, 16'h0028, 7, "ign_start");
        expq.push_back(V_IDLE);
        step(0, 1'b0, "ign_start_idle");

        // start held high: DONE, one IDLE, then the next LOAD_X
        launch(0, 1, 0, 3, 4);
        seq(0, 16'hFFFF, 7, "held_a");
        push_trace(0);
        r2q.push_back(16'd19);
        seq(0, 16'h0000, 7, "held_b");

        // reset in the middle of ADD1
        launch(0, 1, 0, 3, 4);
        seq(0, 16'h0000, 2, "rst_mid");
        chk("rst_mid_add1", 16'(obs(0)), 16'(V_ADD1));
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_async", 16'(obs(0)), 16'(V_IDLE));
        expq.delete();
        r2q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_nodone", 16'(done1), 16'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", 16'(obs(0)), 16'(V_IDLE));
        launch(0, 1, 0, 3, 4);
        seq(0, 16'h0000, 7, "post_rst");

`ifdef BC_ABORT_EN
        launch(0, 1, 0, 3, 4);
        seq(0, 16'h0000, 1, "abort_lx");
        abort1 = 1'b1;
        #1;
        chk("abort_strobes", 16'({LX1, LH1, LS1}), 16'd0);
        expq.delete();
        r2q.delete();
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_idle", 16'(obs(0)), 16'(V_IDLE));
        @(negedge clk);
        chk("abort_nodone", 16'(obs(0)), 16'(V_IDLE));

        abort1 = 1'b1;
        launch(0, 2, 3, 5, 3);
        abort1 = 1'b0;
        seq(0, 16'h0000, 7, "abort_in_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
